spu_sm_normu: RTL and testbench

SPU_SM_NORMU -- requirements
Module: spu_sm_normu

---
 rtl/spu_sm_normu_pkg.sv | 23 ++
 rtl/spu_sm_normu_reci_div.sv | 101 ++++++++++
 rtl/spu_sm_normu.sv | 97 +++++++++
 tb/tb_spu_sm_normu.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_sm_normu_pkg.sv
// Shared SPU softmax definitions: phase encodings used by the exp unit and the
// normalizer, plus the fixed reciprocal dividend and probability rounding constants.
package spu_sm_normu_pkg;

   typedef enum logic [2:0] {
      SM_IDLE = 3'b000,
      SM_EU_A = 3'b001,
      SM_RECI = 3'b011,
      SM_EU_B = 3'b100,
      SM_MAX  = 3'b101
   } sm_state_t;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_RUN  = 1'b1
   } div_state_t;

   // 255 << 16: the reciprocal is pre-scaled so that prob = exp * reci >> 16 lands on 0..255
   localparam logic [23:0] RECI_DIVIDEND = 24'hFF0000;
   localparam int          PROB_FRAC_W   = 16;
   localparam logic [15:0] PROB_ROUND    = 16'h8000;

endpackage

// File: rtl/spu_sm_normu_reci_div.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// The quotient output holds the last result until the next start or an abort.
//
// state    | meaning
// DIV_IDLE | waiting for start; quotient holds last result (or 0)
// DIV_RUN  | iterating; cnt counts quotient bits still to produce
module spu_sm_reci_div
   import spu_sm_normu_pkg::*;
#(
   parameter int DIV_W = 24,
   parameter int SUM_W = 16
) (
   input  logic             core_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] dividend,
   input  logic [SUM_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quotient
);
   localparam int CNT_W = $clog2(DIV_W + 1);

   div_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   // dividend bits shift out of the top while quotient bits shift in at the bottom
   logic [DIV_W-1:0] dvd_sh;
   logic [SUM_W-1:0] rem, dsr, diff;
   logic [SUM_W:0]   trial;
   logic             q_bit, load, step, finish, zero_div;

   assign trial = {rem, dvd_sh[DIV_W-1]};
   assign q_bit = (trial >= {1'b0, dsr});
   assign diff  = trial[SUM_W-1:0] - dsr;
   assign busy  = (state == DIV_RUN);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      zero_div  = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (start && !abort) begin
               if (divisor == '0) begin
                  zero_div = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = DIV_RUN;
               end
            end
         end
         DIV_RUN: begin
            if (abort) begin
               state_nxt = DIV_IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CNT_W'(1)) begin
                  finish    = 1'b1;
                  state_nxt = DIV_IDLE;
               end
            end
         end
         default: state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) state <= DIV_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         dvd_sh   <= '0;
         rem      <= '0;
         dsr      <= '0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= finish | zero_div;
         if (load) begin
            cnt      <= CNT_W'(DIV_W);
            dvd_sh   <= dividend;
            rem      <= '0;
            dsr      <= divisor;
            quotient <= '0;
         end else if (step) begin
            cnt    <= cnt - CNT_W'(1);
            dvd_sh <= {dvd_sh[DIV_W-2:0], q_bit};
            rem    <= q_bit ? diff : trial[SUM_W-1:0];
            if (finish) quotient <= {dvd_sh[DIV_W-2:0], q_bit};
         end
         if (abort || zero_div) quotient <= '0;
      end
   end

endmodule

// File: rtl/spu_sm_normu.sv
// Softmax normalizer: accumulates exp values, computes a scaled reciprocal of the
// sum, then scales each exp by it to give 8-bit probabilities (255 = 1.0).
module spu_sm_normu
   import spu_sm_normu_pkg::*;
#(
   parameter int DIV_W = 24,
   parameter int SUM_W = 16
) (
   input  logic       core_clk,
   input  logic       rst_n,
   input  logic [2:0] sm_state,
   input  logic       exp_valid,
   input  logic [7:0] exp_q,
   output logic       reci_busy,
   output logic       reci_done,
   output logic       sum_ovf,
   output logic       prob_valid,
   output logic [7:0] prob_q
);
   localparam int PROD_W  = DIV_W + 8;
   localparam int SCALE_W = PROD_W + 1 - PROB_FRAC_W;

   logic [2:0]         prev_state;
   logic [SUM_W-1:0]   sum;
   logic [SUM_W:0]     sum_add;
   logic [DIV_W-1:0]   reci;
   logic               entry_a, entry_reci, accept_a, accept_b, div_abort;
   logic               s1_valid;
   logic [PROD_W-1:0]  s1_product;
   logic [SCALE_W-1:0] scaled;
   logic [7:0]         prob_sat;

   assign entry_a    = (sm_state == SM_EU_A) && (prev_state != SM_EU_A);
   assign entry_reci = (sm_state == SM_RECI) && (prev_state != SM_RECI);
   assign accept_a   = (sm_state == SM_EU_A) && exp_valid;
   assign accept_b   = (sm_state == SM_EU_B) && exp_valid;
   // leaving RECI mid-divide discards the result; a new STAGE_A also invalidates reci
   assign div_abort  = (reci_busy && (sm_state != SM_RECI)) || entry_a;
   assign sum_add    = {1'b0, sum} + (SUM_W+1)'(exp_q);

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) prev_state <= SM_IDLE;
      else        prev_state <= sm_state;
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         sum     <= '0;
         sum_ovf <= 1'b0;
      end else if (entry_a) begin
         sum     <= exp_valid ? SUM_W'(exp_q) : '0;
         sum_ovf <= 1'b0;
      end else if (accept_a) begin
         if (sum_add[SUM_W]) begin
            sum     <= '1;
            sum_ovf <= 1'b1;
         end else begin
            sum <= sum_add[SUM_W-1:0];
         end
      end
   end

   spu_sm_reci_div #(
      .DIV_W (DIV_W),
      .SUM_W (SUM_W)
   ) u_reci_div (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .start    (entry_reci),
      .abort    (div_abort),
      .dividend (DIV_W'(RECI_DIVIDEND)),
      .divisor  (sum),
      .busy     (reci_busy),
      .done     (reci_done),
      .quotient (reci)
   );

   always_comb begin
      scaled   = SCALE_W'(({1'b0, s1_product} + (PROD_W+1)'(PROB_ROUND)) >> PROB_FRAC_W);
      prob_sat = (|scaled[SCALE_W-1:8]) ? 8'hFF : scaled[7:0];
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_product <= '0;
         prob_valid <= 1'b0;
         prob_q     <= '0;
      end else begin
         s1_valid <= accept_b;
         if (accept_b) s1_product <= PROD_W'(exp_q) * PROD_W'(reci);
         prob_valid <= s1_valid;
         if (s1_valid) prob_q <= prob_sat;
      end
   end

endmodule

// File: tb/tb_spu_sm_normu.sv
// Self-checking bench for spu_sm_normu: directed softmax scenarios plus randomized
// rounds compared against an arithmetic reference of sum, reciprocal and probability.
module tb_spu_sm_normu;
   import spu_sm_normu_pkg::*;

   logic       core_clk = 1'b0;
   logic       rst_n    = 1'b0;
   logic [2:0] sm_state = SM_IDLE;
   logic       exp_valid = 1'b0;
   logic [7:0] exp_q    = 8'd0;
   logic       reci_busy, reci_done, sum_ovf, prob_valid;
   logic [7:0] prob_q;

   always #5 core_clk = ~core_clk;

   spu_sm_normu #(.DIV_W(24), .SUM_W(16)) dut (
      .core_clk   (core_clk),
      .rst_n      (rst_n),
      .sm_state   (sm_state),
      .exp_valid  (exp_valid),
      .exp_q      (exp_q),
      .reci_busy  (reci_busy),
      .reci_done  (reci_done),
      .sum_ovf    (sum_ovf),
      .prob_valid (prob_valid),
      .prob_q     (prob_q)
   );

   int     n_checks = 0;
   int     n_fail   = 0;
   longint msum     = 0;
   bit     movf     = 0;
   longint mreci    = 0;
   int     last_prob = 0;

   function automatic longint model_reci(longint s);
      return (s == 0) ? 0 : 64'hFF0000 / s;
   endfunction

   function automatic int model_prob(int e, longint r);
      longint v;
      v = (e * r + 32768) / 65536;
      return (v > 255) ? 255 : int'(v);
   endfunction

   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic do_stage_a(input int exps[$], input string tag);
      sm_state = SM_EU_A;
      msum = 0;
      movf = 0;
      if (exps.size() == 0) begin
         exp_valid = 1'b0;
         tick();
      end
      foreach (exps[i]) begin
         exp_valid = 1'b1;
         exp_q     = 8'(exps[i]);
         tick();
         msum += exps[i];
         if (msum > 65535) begin
            msum = 65535;
            movf = 1;
         end
      end
      exp_valid = 1'b0;
      n_checks++;
      if (dut.sum !== 16'(msum)) begin
         n_fail++;
         $display("FAIL %s_sum: got %0d expected %0d", tag, dut.sum, msum);
      end
      n_checks++;
      if (sum_ovf !== movf) begin
         n_fail++;
         $display("FAIL %s_ovf: got %0b expected %0b", tag, sum_ovf, movf);
      end
   endtask

   task automatic run_reci(input string tag);
      int done_at, busy_cnt, done_cnt, exp_lat;
      longint exp_r;
      exp_r    = model_reci(msum);
      exp_lat  = (msum == 0) ? 1 : 25;
      done_at  = -1;
      busy_cnt = 0;
      done_cnt = 0;
      sm_state  = SM_RECI;
      exp_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (reci_busy === 1'b1) busy_cnt++;
         if (reci_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = n;
               n_checks++;
               if (dut.reci !== 24'(exp_r)) begin
                  n_fail++;
                  $display("FAIL %s_reci: got %0h expected %0h", tag, dut.reci, exp_r);
               end
            end
         end
      end
      n_checks++;
      if (done_at != exp_lat) begin
         n_fail++;
         $display("FAIL %s_done_latency: got %0d expected %0d", tag, done_at, exp_lat);
      end
      n_checks++;
      if (busy_cnt != exp_lat - 1) begin
         n_fail++;
         $display("FAIL %s_busy_cycles: got %0d expected %0d", tag, busy_cnt, exp_lat - 1);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt);
      end
      mreci = exp_r;
   endtask

   // Drives samples in EU_STAGE_B, then drains in IDLE; checks each output 2 cycles later.
   task automatic stage_b(input int exps[$], input bit vals[$], input string tag);
      int n, e, p;
      n = exps.size();
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            sm_state  = SM_EU_B;
            exp_valid = vals[k];
            exp_q     = 8'(exps[k]);
         end else begin
            sm_state  = SM_IDLE;
            exp_valid = 1'b0;
         end
         tick();
         if (k >= 1) begin
            e = exps[k-1];
            n_checks++;
            if (prob_valid !== vals[k-1]) begin
               n_fail++;
               $display("FAIL %s_valid[%0d]: got %0b expected %0b", tag, k-1, prob_valid, vals[k-1]);
            end
            if (vals[k-1]) begin
               p = model_prob(e, mreci);
               last_prob = p;
            end
            n_checks++;
            if (prob_q !== 8'(last_prob)) begin
               n_fail++;
               $display("FAIL %s_prob[%0d]: got %0d expected %0d (exp %0d)", tag, k-1, prob_q, last_prob, e);
            end
         end
      end
      tick();
      n_checks++;
      if (prob_valid !== 1'b0 || prob_q !== 8'(last_prob)) begin
         n_fail++;
         $display("FAIL %s_hold: got valid %0b prob %0d expected valid 0 prob %0d", tag, prob_valid, prob_q, last_prob);
      end
   endtask

   task automatic check_all_zero(input string tag);
      n_checks++;
      if ({reci_busy, reci_done, sum_ovf, prob_valid, prob_q} !== 12'd0 || dut.reci !== 24'd0) begin
         n_fail++;
         $display("FAIL %s: got busy %0b done %0b ovf %0b pv %0b prob %0d reci %0h expected all 0",
                  tag, reci_busy, reci_done, sum_ovf, prob_valid, prob_q, dut.reci);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sm_state = SM_IDLE;
      exp_valid = 1'b0;
      repeat (3) tick();
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int ea[$], eb[$];
      bit vb[$];
      ea = '{100, 50, 50, 55};
      do_stage_a(ea, "basic");
      run_reci("basic");
      eb = '{100};
      vb = '{1};
      stage_b(eb, vb, "basic_b");
   endtask

   task automatic test_small_sum();
      int ea[$], eb[$];
      bit vb[$];
      ea = '{1, 1, 1};
      do_stage_a(ea, "small");
      run_reci("small");
      eb = '{1, 3};
      vb = '{1, 1};
      stage_b(eb, vb, "small_b");
   endtask

   task automatic test_zero_sum();
      int ea[$], eb[$];
      bit vb[$];
      do_stage_a(ea, "zero");
      run_reci("zero");
      eb = '{0};
      vb = '{1};
      stage_b(eb, vb, "zero_b");
   endtask

   task automatic test_overflow();
      int ea[$], eb[$];
      bit vb[$];
      for (int i = 0; i < 300; i++) ea.push_back(255);
      do_stage_a(ea, "ovf");
      run_reci("ovf");
      eb = '{255};
      vb = '{1};
      stage_b(eb, vb, "ovf_b");
      ea.delete();
      do_stage_a(ea, "ovf_clear");
   endtask

   task automatic test_abort();
      int ea[$], eb[$];
      bit vb[$];
      int busy_cnt, done_cnt;
      ea = '{10, 20};
      do_stage_a(ea, "abort");
      sm_state = SM_RECI;
      busy_cnt = 0;
      done_cnt = 0;
      repeat (10) begin
         tick();
         if (reci_busy === 1'b1) busy_cnt++;
         if (reci_done === 1'b1) done_cnt++;
      end
      n_checks++;
      if (busy_cnt != 10) begin
         n_fail++;
         $display("FAIL abort_busy_before: got %0d expected 10", busy_cnt);
      end
      sm_state = SM_IDLE;
      tick();
      n_checks++;
      if (reci_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy_after: got %0b expected 0", reci_busy);
      end
      repeat (30) begin
         if (reci_done === 1'b1) done_cnt++;
         tick();
      end
      n_checks++;
      if (done_cnt != 0 || dut.reci !== 24'd0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %0d pulses reci %0h expected 0 pulses reci 0", done_cnt, dut.reci);
      end
      mreci = 0;
      eb = '{200};
      vb = '{1};
      stage_b(eb, vb, "abort_b");
   endtask

   task automatic test_reset_mid_divide();
      int ea[$], eb[$];
      bit vb[$];
      ea = '{100, 155};
      do_stage_a(ea, "rstmid");
      sm_state = SM_RECI;
      repeat (12) tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("rstmid_outputs");
      msum = 0;
      movf = 0;
      mreci = 0;
      last_prob = 0;
      sm_state = SM_IDLE;
      tick();
      rst_n = 1'b1;
      tick();
      do_stage_a(ea, "rstmid_again");
      run_reci("rstmid_again");
      eb = '{100};
      vb = '{1};
      stage_b(eb, vb, "rstmid_b");
   endtask

   task automatic test_random();
      int ea[$], eb[$];
      bit vb[$];
      int n;
      for (int r = 0; r < 5; r++) begin
         ea.delete();
         eb.delete();
         vb.delete();
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++)
            ea.push_back((r == 0) ? $urandom_range(0, 4) : $urandom_range(0, 255));
         do_stage_a(ea, "rand");
         run_reci("rand");
         for (int i = 0; i < 10; i++) begin
            eb.push_back($urandom_range(0, 255));
            vb.push_back((r == 1) ? 1'b1 : ($urandom_range(0, 3) != 0));
         end
         stage_b(eb, vb, "rand_b");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_small_sum();
      test_zero_sum();
      test_overflow();
      test_abort();
      test_reset_mid_divide();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
